// File: rtl/midi_uart_rx.sv
// midi_uart_rx: MIDI serial receiver (31250 baud, 8N1, LSB first).
// Samples Rx on events of the 16x oversample Tick, where every Tick transition
// counts as one event. Good bytes are presented on Data with a one-cycle
// DataValid strobe; a low stop bit gives a one-cycle FrameErr strobe instead.
// Optional build macro MIDI_RX_MAJORITY_EN: each bit decision becomes a 2-of-3
// vote over the samples taken at the decision event and the two events before it.
module midi_uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Rx,
  output logic [7:0] Data,
  output logic       DataValid,
  output logic       FrameErr,
  output logic       Busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] START_D = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_D   = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic            rx_m;
  logic            rx_s;
  logic            rx_prev;
  logic            tick_d;
  logic            tick_evt;
  logic            fall;
  logic            sample;
  logic [CW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;

  assign tick_evt = Tick ^ tick_d;
  assign fall     = rx_prev & ~rx_s;

  // Two-flop synchronizer for the asynchronous line, edge history and tick edge detect
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      tick_d  <= 1'b0;
    end else begin
      rx_m    <= Rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
      tick_d  <= Tick;
    end
  end

`ifdef MIDI_RX_MAJORITY_EN
  // Together with the live rx_s, these two stored samples form the 3-deep vote window
  logic [1:0] hist;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Record rx_s at every tick event so the two preceding samples are on hand
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hist <= 2'b11;
    end else if (tick_evt) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = maj3(hist[1], hist[0], rx_s);
`else
  assign sample = rx_s;
`endif

  // Frame state machine: start qualification, data shift, stop check and strobes
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      Data      <= 8'h00;
      DataValid <= 1'b0;
      FrameErr  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      DataValid <= 1'b0;
      FrameErr  <= 1'b0;
      case (state)
        IDLE: begin
          // Only a fresh falling edge starts a frame; a tick on the same cycle is dropped
          if (fall) begin
            state    <= START;
            tick_cnt <= '0;
            Busy     <= 1'b1;
          end
        end
        START: begin
          if (tick_evt) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == START_D) begin
              if (!sample) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= 3'd0;
              end else begin
                state <= IDLE;
                Busy  <= 1'b0;
              end
            end
          end
        end
        DATA: begin
          if (tick_evt) begin
            // The counter wraps to zero naturally at the decision event
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == BIT_D) begin
              shift <= {sample, shift[7:1]};
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
        end
        STOP: begin
          if (tick_evt) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == BIT_D) begin
              if (sample) begin
                Data      <= shift;
                DataValid <= 1'b1;
              end else begin
                FrameErr  <= 1'b1;
              end
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx: scoreboard bench for midi_uart_rx. Expected strobes are
// queued as frames are driven and retired by a monitor when DataValid or
// FrameErr fires. Tick spacing is shortened; the receiver only depends on the
// tick-to-bit ratio, so frame behaviour is unchanged.
module tb_midi_uart_rx;

  localparam int TICK = 32;
  localparam int BIT  = 16 * TICK;

  logic       Clk  = 1'b0;
  logic       Rst  = 1'b1;
  logic       Tick = 1'b0;
  logic       Rx   = 1'b1;
  logic [7:0] Data;
  logic       DataValid;
  logic       FrameErr;
  logic       Busy;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  midi_uart_rx #(.OVERSAMPLE(16)) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .Rx(Rx),
    .Data(Data), .DataValid(DataValid), .FrameErr(FrameErr), .Busy(Busy)
  );

  always #10 Clk = ~Clk;

  // Tick toggles every TICK clocks; each toggle is one oversample event
  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (cyc % TICK == 0) Tick = ~Tick;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Retire one scoreboard entry per strobe
  always @(negedge Clk) begin
    if (!Rst && (DataValid || FrameErr)) begin
      check("strobes_exclusive", {31'd0, DataValid & FrameErr}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, DataValid, FrameErr}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", {31'd0, FrameErr}, {31'd0, e.err});
        check("data", {24'd0, Data}, {24'd0, e.data});
      end
    end
  end

  task automatic hold(input logic v, input int n);
    Rx = v;
    repeat (n) @(negedge Clk);
  endtask

  // Line changes land half a tick away from tick events
  task automatic align();
    while (cyc % TICK != TICK / 2) @(negedge Clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v);
    exp_t e;
    if (stop_v) begin
      e = '{err: 1'b0, data: b};
      last_good = b;
    end else begin
      e = '{err: 1'b1, data: last_good};
    end
    sb.push_back(e);
    align();
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop_v, BIT);
  endtask

  initial begin
    logic [7:0] rb;
    exp_t       ne;

    // Reset state
    repeat (5) @(negedge Clk);
    check("rst_data", {24'd0, Data}, 32'h00);
    check("rst_valid", {31'd0, DataValid}, 32'd0);
    check("rst_ferr", {31'd0, FrameErr}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    Rst = 1'b0;
    hold(1'b1, BIT);

    // Single byte
    send(8'h90, 1'b1);
    check("single_busy_low", {31'd0, Busy}, 32'd0);
    check("single_drained", sb.size(), 32'd0);

    // Back-to-back with no idle gap
    send(8'h90, 1'b1);
    send(8'h3C, 1'b1);
    send(8'h7F, 1'b1);
    check("b2b_drained", sb.size(), 32'd0);
    hold(1'b1, BIT);

    // Start glitch: low for 4 ticks only
    align();
    hold(1'b0, 4 * TICK);
    check("glitch_busy_high", {31'd0, Busy}, 32'd1);
    hold(1'b1, BIT);
    check("glitch_busy_low", {31'd0, Busy}, 32'd0);
    check("glitch_data", {24'd0, Data}, 32'h7F);

    // Framing error, then line held low: no retrigger
    send(8'h55, 1'b0);
    hold(1'b0, 5 * BIT);
    check("ferr_no_retrig", {31'd0, Busy}, 32'd0);
    check("ferr_data", {24'd0, Data}, 32'h7F);
    hold(1'b1, 2 * BIT);
    send(8'h3C, 1'b1);
    hold(1'b1, BIT);

    // Reset in the middle of data bit 4
    rb = 8'hAA;
    align();
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(rb[i], BIT);
    hold(rb[4], BIT / 2);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_data", {24'd0, Data}, 32'h00);
    check("midrst_valid", {31'd0, DataValid}, 32'd0);
    check("midrst_ferr", {31'd0, FrameErr}, 32'd0);
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    Rx = 1'b1;
    repeat (5) @(negedge Clk);
    Rst = 1'b0;
    last_good = 8'h00;
    hold(1'b1, BIT);
    check("midrst_idle", {31'd0, Busy}, 32'd0);
    send(8'hF8, 1'b1);
    hold(1'b1, BIT);

    // Noise spike over the bit-3 decision event of a 0x00 frame
`ifdef MIDI_RX_MAJORITY_EN
    ne = '{err: 1'b0, data: 8'h00};
`else
    ne = '{err: 1'b0, data: 8'h08};
`endif
    sb.push_back(ne);
    align();
    hold(1'b0, BIT);
    for (int i = 0; i < 3; i++) hold(1'b0, BIT);
    hold(1'b0, BIT / 2 - TICK);
    hold(1'b1, TICK);
    hold(1'b0, BIT / 2 + TICK);
    for (int i = 4; i < 8; i++) hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b1, BIT);

    check("final_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
